// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide engine for the multicycle datapath.
// Shift-add multiply and restoring divide on operand magnitudes, with a
// sign fixup pass that writes HI/LO, plus a busy/done handshake and a
// sticky divide-by-zero flag.
module mult_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIXUP,
    DONE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [2*WIDTH-1:0]     acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]       opb;      // mult: multiplicand magnitude; div: divisor magnitude
  logic                   op_div;
  logic                   sgn_op;
  logic                   sign_a;
  logic                   sign_b;

  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic [WIDTH:0]         mult_sum;
  logic [WIDTH:0]         div_partial;
  logic [WIDTH:0]         div_diff;
  logic                   neg_result;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quot_fix;
  logic [WIDTH-1:0]       rem_fix;

  // Operand magnitudes, per-step datapath and final sign correction
  always_comb begin
    mag_a       = (signed_op && A[WIDTH-1]) ? -A : A;
    mag_b       = (signed_op && B[WIDTH-1]) ? -B : B;
    mult_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    // remainder shifted left with the next dividend bit brought in
    div_partial = acc[2*WIDTH-1:WIDTH-1];
    div_diff    = div_partial - {1'b0, opb};
    neg_result  = sgn_op && (sign_a ^ sign_b);
    prod_fix    = neg_result ? -acc : acc;
    quot_fix    = neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix     = (sgn_op && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      op_div  <= 1'b0;
      sgn_op  <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (mult_start || div_start) begin
            busy    <= 1'b1;
            divzero <= 1'b0;
            cnt     <= '0;
            sgn_op  <= signed_op;
            sign_a  <= signed_op & A[WIDTH-1];
            sign_b  <= signed_op & B[WIDTH-1];
            op_div  <= !mult_start;
            if (mult_start) begin
              acc   <= {{WIDTH{1'b0}}, mag_b};
              opb   <= mag_a;
              state <= MULT;
            end else begin
              acc   <= {{WIDTH{1'b0}}, mag_a};
              opb   <= mag_b;
              state <= DIV;
            end
          end
        end
        MULT: begin
          acc <= {mult_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
        end
        DIV: begin
          if (opb == '0) begin
            divzero <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {acc[2*WIDTH-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIXUP;
          end
        end
        FIXUP: begin
          if (op_div) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
`timescale 1ns/1ps
module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .signed_op(signed_op), .A(A), .B(B), .busy(busy), .done(done),
    .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers; divide by zero leaves HI/LO alone.
  task automatic model(input bit is_div, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output bit dz);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    dz = 1'b0;
    if (!is_div) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b == 0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end
  endtask

  // Issue one operation and follow it to completion, checking the handshake timing.
  task automatic run_op(input string tag, input bit is_div, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit both, input int inject_at);
    int edges, done_cnt, first_done, fall_edge, exp_done;
    bit dz;
    model(is_div && !both, sgn, a, b, dz);
    exp_done = dz ? 2 : 34;
    @(negedge clk);
    mult_start = !is_div || both;
    div_start  = is_div || both;
    signed_op  = sgn;
    A = a;
    B = b;
    edges = 0; done_cnt = 0; first_done = -1; fall_edge = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      A = $urandom;
      B = $urandom;
      signed_op = $urandom_range(0, 1);
      if (edges == inject_at) begin
        mult_start = 1'b1;
        div_start  = 1'b1;
      end
      if (edges == 1) begin
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        check({tag, " divzero_cleared"}, 64'(divzero), 64'd0);
      end
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = edges;
      end
      if (!busy) begin
        fall_edge = edges;
        break;
      end
    end
    check({tag, " done_edge"}, 64'(first_done), 64'(exp_done));
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_fall_edge"}, 64'(fall_edge), 64'(exp_done + 1));
    check({tag, " divzero"}, 64'(divzero), 64'(dz));
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    bit          r_div, r_sgn;
    logic [31:0] r_a, r_b;
    int          sel;

    // reset state
    #3;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset divzero", 64'(divzero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("smult_7_m3", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0, -1);
    check("smult_7_m3 hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("smult_7_m3 lo_const", 64'(lo), 64'hFFFF_FFEB);

    run_op("umult_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5);
    check("umult_max hi_const", 64'(hi), 64'hFFFF_FFFE);
    check("umult_max lo_const", 64'(lo), 64'h0000_0001);

    run_op("sdiv_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    check("sdiv_m7_2 lo_const", 64'(lo), 64'hFFFF_FFFD);
    check("sdiv_m7_2 hi_const", 64'(hi), 64'hFFFF_FFFF);

    run_op("sdiv_min_m1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    check("sdiv_min_m1 lo_const", 64'(lo), 64'h8000_0000);
    check("sdiv_min_m1 hi_const", 64'(hi), 64'd0);

    run_op("udiv_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 1'b0, -1);
    check("udiv_100_7 lo_const", 64'(lo), 64'd14);
    check("udiv_100_7 hi_const", 64'(hi), 64'd2);

    // preload hi=0x11 lo=0x22 (0x22 * 0x80000001), then divide by zero
    run_op("preload", 1'b0, 1'b0, 32'h22, 32'h8000_0001, 1'b0, -1);
    check("preload hi_const", 64'(hi), 64'h11);
    check("preload lo_const", 64'(lo), 64'h22);
    run_op("div_by_zero", 1'b1, 1'b0, 32'd10, 32'd0, 1'b0, -1);
    repeat (5) @(negedge clk);
    check("divzero sticky", 64'(divzero), 64'd1);
    check("divzero hi_hold", 64'(hi), 64'h11);
    check("divzero lo_hold", 64'(lo), 64'h22);

    run_op("both_starts", 1'b0, 1'b0, 32'd3, 32'd4, 1'b1, -1);
    check("both_starts lo_const", 64'(lo), 64'd12);
    repeat (4) @(negedge clk);
    check("both_starts no_follow_busy", 64'(busy), 64'd0);
    check("both_starts lo_hold", 64'(lo), 64'd12);

    // asynchronous reset during multiply iteration 10
    @(negedge clk);
    mult_start = 1'b1; signed_op = 1'b1; A = 32'd5; B = 32'd9;
    @(posedge clk);
    @(negedge clk);
    mult_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset busy", 64'(busy), 64'd0);
    check("async_reset done", 64'(done), 64'd0);
    check("async_reset hi", 64'(hi), 64'd0);
    check("async_reset lo", 64'(lo), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    run_op("post_reset_smult", 1'b0, 1'b1, 32'd2, 32'd3, 1'b0, -1);
    check("post_reset_smult lo_const", 64'(lo), 64'd6);

    // randomized operations against the reference arithmetic
    for (int i = 0; i < 24; i++) begin
      r_div = $urandom_range(0, 1);
      r_sgn = $urandom_range(0, 1);
      r_a = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      r_b = 32'd0;
      else if (sel == 1) r_b = 32'($urandom_range(1, 15));
      else if (sel == 2) r_b = 32'hFFFF_FFFF;
      else               r_b = $urandom;
      if ($urandom_range(0, 5) == 0) r_a = 32'h8000_0000;
      run_op($sformatf("rand%0d", i), r_div, r_sgn, r_a, r_b, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Parametrised iterative multiply/divide engine driven by the multicycle control unit's mult_start/div_start strobes.
- Generalises the fixed 32-bit mult/div path in three ways: operand width is set by WIDTH; signed and unsigned modes are supported; a done/busy handshake lets the control FSM wait without hardcoded cycle counts.
- Results go to the HI/LO registers (HI_write/LO_write/HiLoSrc path); divide-by-zero is flagged to the exception states.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mult_start  input  1  one-cycle request: multiply A by B.
- div_start  input  1  one-cycle request: divide A by B.
- signed_op  input  1  1 = signed (mult/div), 0 = unsigned (multu/divu); sampled with start.
- A  input  WIDTH  multiplicand / dividend.
- B  input  WIDTH  multiplier / divisor.
- busy  output  1  high from the accepting edge until done deasserts.
- done  output  1  one-cycle completion pulse.
- divzero  output  1  divide-by-zero flag; sticky until the next accepted start.
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0. busy=0, done=0, divzero=0, hi=0, lo=0. A reset mid-operation aborts it and no result is written.
- States: IDLE, MULT, DIV, FIXUP, DONE.
- IDLE:
  - The first rising edge seeing a start accepts it. A, B and signed_op are captured, busy=1 and divzero is cleared.
  - Signed mode: operand magnitudes are formed and sign flags stored.
  - Both starts high: mult_start wins and div_start is ignored.
- Start pulses while busy=1 are ignored; captured operands are unaffected.
- MULT:
  - Unsigned shift-add of magnitudes.
  - 2*WIDTH-bit accumulator, one multiplier bit per edge, WIDTH edges, then FIXUP.
- DIV:
  - If captured B==0: go directly to DONE with divzero=1; hi/lo keep their prior values.
  - Otherwise: restoring division of magnitudes, one quotient bit per edge, WIDTH edges, then FIXUP.
- FIXUP, one edge; writes hi/lo:
  - Mult: if signed and the operand signs differ, the 2*WIDTH product is two's-complement negated. hi=upper half, lo=lower half.
  - Div: lo=quotient, negated if signed and the signs differ. hi=remainder, taking the dividend's sign when signed.
  - Signed MIN / -1: lo=MIN (wraps), hi=0; no flag raised.
- DONE, one edge: done=1 for exactly one cycle, then IDLE with busy=0 on the following edge.
- Latency, counting the accepting edge as edge 1:
  - Normal op: done is high in the cycle after edge WIDTH+2; busy falls after edge WIDTH+3.
  - Div-by-zero: done is high after edge 2.
- A new start may be accepted on the same edge that returns to IDLE? No. It is accepted only from IDLE, i.e. from the cycle in which busy=0.
- hi/lo hold their values between operations; they change only in FIXUP or on reset.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=32, signed mult of 7 by 0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. done pulses exactly once, after edge 34; busy is high throughout.
- Unsigned mult 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A mult_start issued at iteration 5 is ignored; the result is unchanged.
- Signed div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Unsigned div 100/7 -> lo=14, hi=2.
- Preload hi=0x11, lo=0x22 via a mult; then div 10/0 -> divzero=1 and done after edge 2; hi/lo stay 0x11/0x22. divzero stays 1 until the next accepted start, then clears.
- mult_start and div_start asserted together with A=3, B=4 -> multiply is performed (lo=12, hi=0); no divide follows.
- reset driven low asynchronously mid-clock during multiply iteration 10 -> immediately busy=0, done=0, hi=lo=0. After release, signed mult 2 × 3 completes normally with lo=6.
